// File: rtl/calc_pkg.sv
// Shared types, constants and helpers for the calculator display scan controller.
package calc_pkg;

  localparam int unsigned OP_W        = 7;
  localparam int unsigned BCD_W       = 8;
  localparam int unsigned CONV_CYCLES = 14;
  localparam int unsigned BCD_MAX     = 99;

  typedef enum logic [1:0] {
    SLOT_N1_ONES = 2'd0,
    SLOT_N1_TENS = 2'd1,
    SLOT_N2_ONES = 2'd2,
    SLOT_N2_TENS = 2'd3
  } slot_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [OP_W-1:0] clamp_bcd(input logic [OP_W-1:0] v);
    return (v > OP_W'(BCD_MAX)) ? OP_W'(BCD_MAX) : v;
  endfunction

  // One double-dabble step: add-3 correction on each nibble, then shift in bit_in.
  function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] bcd, input logic bit_in);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = (bcd[7:4] >= 4'd5) ? bcd[7:4] + 4'd3 : bcd[7:4];
    lo = (bcd[3:0] >= 4'd5) ? bcd[3:0] + 4'd3 : bcd[3:0];
    return {hi[2:0], lo, bit_in};
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-low seven-segment decode; 10-15 decode blank.
module bcd_to_seg
  import calc_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (nibble)
      4'd0: seg_c = SEG_0;
      4'd1: seg_c = SEG_1;
      4'd2: seg_c = SEG_2;
      4'd3: seg_c = SEG_3;
      4'd4: seg_c = SEG_4;
      4'd5: seg_c = SEG_5;
      4'd6: seg_c = SEG_6;
      4'd7: seg_c = SEG_7;
      4'd8: seg_c = SEG_8;
      4'd9: seg_c = SEG_9;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/calc_display_scan_ctrl.sv
// Two-operand BCD conversion and 4-digit seven-segment scan controller.
// Optional leading-zero blanking of the tens slots: CALC_BLANK_LEADING_ZERO_EN.
module calc_display_scan_ctrl
  import calc_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [OP_W-1:0]  num1,
  input  logic [OP_W-1:0]  num2,
  output logic             busy,
  output logic [1:0]       digit_sel,
  output logic [3:0]       an,
  output logic [6:0]       seg
);

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

  state_e           state;
  state_e           state_nxt;
  logic [3:0]       shift_cnt;
  logic [OP_W-1:0]  op1;
  logic [OP_W-1:0]  op2;
  logic [BCD_W-1:0] bcd1;
  logic [BCD_W-1:0] bcd2;
  logic [3:0][3:0]  nib;

  logic [PW-1:0]    presc;
  logic             tick_c;
  logic [1:0]       sel_nxt_c;
  logic [3:0]       nib_sel_c;
  logic [6:0]       seg_dec_c;
  logic             blank_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (load) state_nxt = ST_CONV;
      ST_CONV:   if (shift_cnt == 4'(CONV_CYCLES - 1)) state_nxt = ST_COMMIT;
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Conversion datapath: first 7 steps shift num1, last 7 shift num2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      shift_cnt <= '0;
      op1       <= '0;
      op2       <= '0;
      bcd1      <= '0;
      bcd2      <= '0;
      nib       <= '0;
    end else begin
      busy <= (state_nxt != ST_IDLE);
      case (state)
        ST_IDLE: if (load) begin
          op1       <= clamp_bcd(num1);
          op2       <= clamp_bcd(num2);
          bcd1      <= '0;
          bcd2      <= '0;
          shift_cnt <= '0;
        end
        ST_CONV: begin
          shift_cnt <= shift_cnt + 4'd1;
          if (shift_cnt < 4'(OP_W)) begin
            bcd1 <= dd_step(bcd1, op1[OP_W-1]);
            op1  <= op1 << 1;
          end else begin
            bcd2 <= dd_step(bcd2, op2[OP_W-1]);
            op2  <= op2 << 1;
          end
        end
        ST_COMMIT: nib <= {bcd2[7:4], bcd2[3:0], bcd1[7:4], bcd1[3:0]};
        default: ;
      endcase
    end
  end

  assign tick_c    = (presc == PRESC_LAST);
  assign sel_nxt_c = digit_sel + 2'd1;
  assign nib_sel_c = nib[sel_nxt_c];

  bcd_to_seg u_bcd_to_seg (
    .nibble (nib_sel_c),
    .seg_c  (seg_dec_c)
  );

`ifdef CALC_BLANK_LEADING_ZERO_EN
  assign blank_c = ((slot_e'(sel_nxt_c) == SLOT_N1_TENS) || (slot_e'(sel_nxt_c) == SLOT_N2_TENS))
                   && (nib_sel_c == 4'd0);
`else
  assign blank_c = 1'b0;
`endif

  // Free-running scan; the tick reads the nibbles held before any same-cycle commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc     <= '0;
      digit_sel <= 2'd0;
      an        <= 4'hF;
      seg       <= SEG_BLANK;
    end else begin
      presc <= tick_c ? '0 : presc + PW'(1);
      if (tick_c) begin
        digit_sel <= sel_nxt_c;
        an        <= blank_c ? 4'hF : ~(4'b0001 << sel_nxt_c);
        seg       <= blank_c ? SEG_BLANK : seg_dec_c;
      end
    end
  end

endmodule

// File: tb/tb_calc_display_scan_ctrl.sv
// Self-checking bench for calc_display_scan_ctrl against a digit-level reference model.
module tb_calc_display_scan_ctrl;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [6:0] num1 = '0;
  logic [6:0] num2 = '0;
  logic       busy, busy1;
  logic [1:0] digit_sel, digit_sel1;
  logic [3:0] an, an1;
  logic [6:0] seg, seg1;

  int n_cmp = 0;
  int n_err = 0;
  int ecyc;
  int m1 = 0;
  int m2 = 0;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  calc_display_scan_ctrl #(.REFRESH_DIV(DIV)) u_dut (
    .clk(clk), .rst_n(rst_n), .load(load), .num1(num1), .num2(num2),
    .busy(busy), .digit_sel(digit_sel), .an(an), .seg(seg)
  );

  calc_display_scan_ctrl #(.REFRESH_DIV(1)) u_dut_div1 (
    .clk(clk), .rst_n(rst_n), .load(load), .num1(num1), .num2(num2),
    .busy(busy1), .digit_sel(digit_sel1), .an(an1), .seg(seg1)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecyc <= 0;
    else        ecyc <= ecyc + 1;
  end

  function automatic int exp_digit(input int slot);
    case (slot)
      0: return m1 % 10;
      1: return m1 / 10;
      2: return m2 % 10;
      default: return m2 / 10;
    endcase
  endfunction

  function automatic bit exp_blank(input int slot);
`ifdef CALC_BLANK_LEADING_ZERO_EN
    return (slot % 2 == 1) && (exp_digit(slot) == 0);
`else
    return 1'b0;
`endif
  endfunction

  // Expected {digit_sel, an, seg} for the current cycle, from edges since reset.
  function automatic logic [12:0] exp_pins();
    int s;
    logic [3:0] one;
    one = 4'b0001;
    s = (ecyc / DIV) % 4;
    if (ecyc < DIV) return {2'd0, 4'hF, 7'h7F};
    if (exp_blank(s)) return {2'(s), 4'hF, 7'h7F};
    return {2'(s), ~(one << s), seg_tab[exp_digit(s)]};
  endfunction

  task automatic pulse_load(input int a, input int b);
    num1 = 7'(a);
    num2 = 7'(b);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  function automatic int clamp(input int v);
    return (v > 99) ? 99 : v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, digit_sel, an, seg} !== {1'b0, 2'd0, 4'hF, 7'h7F}) begin
      n_err++;
      $display("FAIL reset_values: got busy=%b sel=%0d an=%b seg=%h, want 0 0 1111 7f", busy, digit_sel, an, seg);
    end
    m1 = 0; m2 = 0;
    rst_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({digit_sel, an, seg} !== exp_pins()) begin
        n_err++;
        $display("FAIL reset_scan cyc%0d: got %b want %b", ecyc, {digit_sel, an, seg}, exp_pins());
      end
    end
  endtask

  task automatic test_div1();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++;
      if (digit_sel1 !== 2'(ecyc % 4)) begin
        n_err++;
        $display("FAIL div1_sel: got %0d want %0d", digit_sel1, ecyc % 4);
      end
    end
  endtask

  task automatic test_convert(input int a, input int b);
    int n;
    pulse_load(a, b);
    count_busy(n);
    n_cmp++;
    if (n !== 15) begin
      n_err++;
      $display("FAIL busy_len %0d/%0d: got %0d want 15", a, b, n);
    end
    m1 = clamp(a); m2 = clamp(b);
    repeat (4 * DIV) @(negedge clk);
    for (int i = 0; i < 4 * DIV; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({digit_sel, an, seg} !== exp_pins()) begin
        n_err++;
        $display("FAIL display %0d/%0d: got %b want %b", a, b, {digit_sel, an, seg}, exp_pins());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) test_convert(int'($urandom_range(0, 127)), int'($urandom_range(0, 127)));
  endtask

  task automatic test_dropped_load();
    int n;
    pulse_load(21, 64);
    repeat (4) @(negedge clk);
    pulse_load(88, 3);
    count_busy(n);
    n_cmp++;
    if (n !== 10) begin
      n_err++;
      $display("FAIL drop_busy_len: got %0d want 10", n);
    end
    m1 = 21; m2 = 64;
    repeat (4 * DIV) @(negedge clk);
    for (int i = 0; i < 4 * DIV; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({digit_sel, an, seg} !== exp_pins()) begin
        n_err++;
        $display("FAIL drop_display: got %b want %b", {digit_sel, an, seg}, exp_pins());
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    pulse_load(36, 80);
    count_busy(n);
    pulse_load(58, 17);
    count_busy(n);
    n_cmp++;
    if (n !== 15) begin
      n_err++;
      $display("FAIL b2b_busy_len: got %0d want 15", n);
    end
    m1 = 58; m2 = 17;
    repeat (4 * DIV) @(negedge clk);
    for (int i = 0; i < 4 * DIV; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({digit_sel, an, seg} !== exp_pins()) begin
        n_err++;
        $display("FAIL b2b_display: got %b want %b", {digit_sel, an, seg}, exp_pins());
      end
    end
  endtask

  task automatic test_reset_mid_conv();
    pulse_load(77, 66);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, digit_sel, an, seg} !== {1'b0, 2'd0, 4'hF, 7'h7F}) begin
      n_err++;
      $display("FAIL midconv_reset: got busy=%b sel=%0d an=%b seg=%h, want 0 0 1111 7f", busy, digit_sel, an, seg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m1 = 0; m2 = 0;
    repeat (4 * DIV) @(negedge clk);
    for (int i = 0; i < 4 * DIV; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({digit_sel, an, seg} !== exp_pins()) begin
        n_err++;
        $display("FAIL midconv_lost_display: got %b want %b", {digit_sel, an, seg}, exp_pins());
      end
    end
    test_convert(13, 55);
  endtask

  initial begin
    test_reset();
    test_div1();
    test_convert(42, 7);
    test_convert(127, 100);
    test_convert(0, 9);
    test_convert(99, 10);
    test_random();
    test_dropped_load();
    test_back_to_back();
    test_reset_mid_conv();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
